sram_responder: RTL and testbench

- Synthesizable clocked model of the 8-bit asynchronous SRAM (HM628128-class) as seen from its pins.
- Sits on the far side of the ram_addr/ram_dq/ram_we_/ram_oe_ bus and answers the existing SRAM controller.
- Used in simulation and on-FPGA loopback, so controller microcode timing can be verified without the physical chip.
- Stores data, enforces minimum pulse widths and flags protocol violations.

---
 rtl/sram_responder_if.sv | 21 ++
 rtl/sram_responder.sv | 142 ++++++++++++++
 tb/tb_sram_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - pin-level bus between the SRAM controller and the sram_responder model
interface sram_responder_if #(
  parameter int ALEN = 16
) ();
  logic [ALEN-1:0] ram_addr;
  logic            ram_we_;
  logic            ram_oe_;
  logic [7:0]      ram_dq_in;
  logic [7:0]      ram_dq_out;
  logic            ram_dq_oe;

  modport master (
    output ram_addr, ram_we_, ram_oe_, ram_dq_in,
    input  ram_dq_out, ram_dq_oe
  );

  modport slave (
    input  ram_addr, ram_we_, ram_oe_, ram_dq_in,
    output ram_dq_out, ram_dq_oe
  );
endinterface

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - clocked HM628128-class SRAM pin model; `SRAM_RESP_TIMING_CHECK_EN enables pulse-width enforcement and err flags
module sram_responder #(
  parameter int ALEN     = 16,
  parameter int T_ACC    = 2,
  parameter int T_WP_MIN = 3
) (
  input  logic                clk,
  input  logic                rst,
  sram_responder_if.slave     bus,
  output logic [15:0]         wr_count,
  output logic [15:0]         rd_count,
  output logic [2:0]          err
);

`ifdef SRAM_RESP_TIMING_CHECK_EN
  localparam bit TIMING_CHECK = 1'b1;
`else
  localparam bit TIMING_CHECK = 1'b0;
`endif

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WRITE      = 2'd1;
  localparam logic [1:0] S_READ_ACC   = 2'd2;
  localparam logic [1:0] S_READ_VALID = 2'd3;

  localparam logic [2:0] T_ACC_C    = 3'(T_ACC);
  localparam logic [2:0] T_WP_MIN_C = 3'(T_WP_MIN);

  logic [7:0]      mem [0:(2**ALEN)-1];
  logic [1:0]      state;
  logic [ALEN-1:0] lat_addr;
  logic [2:0]      wp_cnt;
  logic [2:0]      acc_cnt;
  logic [7:0]      wdata;
  logic [7:0]      dq_out;
  logic            dq_oe;
  logic            commit;
  logic            addr_moved;

  assign bus.ram_dq_out = dq_out;
  assign bus.ram_dq_oe  = dq_oe;

  // Without timing checks every write that reached WRITE has at least one low sample and commits.
  assign commit     = !TIMING_CHECK || (wp_cnt >= T_WP_MIN_C);
  assign addr_moved = (bus.ram_addr != lat_addr);

  // Storage is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && state == S_WRITE && bus.ram_we_ && commit) begin
      mem[lat_addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      lat_addr <= '0;
      wp_cnt   <= 3'd0;
      acc_cnt  <= 3'd0;
      wdata    <= 8'h00;
      dq_out   <= 8'h00;
      dq_oe    <= 1'b0;
      wr_count <= 16'h0000;
      rd_count <= 16'h0000;
      err      <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          dq_oe <= 1'b0;
          if (!bus.ram_we_) begin
            lat_addr <= bus.ram_addr;
            wp_cnt   <= 3'd1;
            wdata    <= bus.ram_dq_in;
            state    <= S_WRITE;
          end else if (!bus.ram_oe_) begin
            lat_addr <= bus.ram_addr;
            acc_cnt  <= 3'd1;
            state    <= S_READ_ACC;
          end
        end

        S_WRITE: begin
          if (!bus.ram_we_) begin
            wp_cnt <= (wp_cnt == 3'd7) ? 3'd7 : wp_cnt + 3'd1;
            wdata  <= bus.ram_dq_in;
            if (TIMING_CHECK && addr_moved) begin
              err[1] <= 1'b1;
            end
          end else begin
            if (commit) begin
              wr_count <= wr_count + 16'd1;
            end else if (TIMING_CHECK) begin
              err[0] <= 1'b1;
            end
            state <= S_IDLE;
          end
        end

        S_READ_ACC, S_READ_VALID: begin
          if (!bus.ram_we_) begin
            // A write preempts the read; the read is abandoned uncounted.
            if (TIMING_CHECK && !bus.ram_oe_) begin
              err[2] <= 1'b1;
            end
            dq_oe    <= 1'b0;
            lat_addr <= bus.ram_addr;
            wp_cnt   <= 3'd1;
            wdata    <= bus.ram_dq_in;
            state    <= S_WRITE;
          end else if (state == S_READ_ACC) begin
            if (bus.ram_oe_) begin
              state <= S_IDLE;
            end else if (acc_cnt >= T_ACC_C) begin
              dq_out <= mem[lat_addr];
              dq_oe  <= 1'b1;
              state  <= S_READ_VALID;
            end else begin
              acc_cnt <= acc_cnt + 3'd1;
            end
          end else begin
            if (bus.ram_oe_) begin
              dq_oe    <= 1'b0;
              rd_count <= rd_count + 16'd1;
              state    <= S_IDLE;
            end else if (addr_moved) begin
              if (TIMING_CHECK) begin
                err[1] <= 1'b1;
              end
              lat_addr <= bus.ram_addr;
              dq_oe    <= 1'b0;
              acc_cnt  <= 3'd1;
              state    <= S_READ_ACC;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - randomized transaction-level check of sram_responder against a reference model
module tb_sram_responder;
  localparam int ALEN     = 16;
  localparam int T_ACC    = 2;
  localparam int T_WP_MIN = 3;

`ifdef SRAM_RESP_TIMING_CHECK_EN
  localparam bit TC = 1'b1;
`else
  localparam bit TC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [2:0]  err;

  always #5 clk = ~clk;

  sram_responder_if #(.ALEN(ALEN)) bus ();

  sram_responder #(.ALEN(ALEN), .T_ACC(T_ACC), .T_WP_MIN(T_WP_MIN)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .wr_count (wr_count),
    .rd_count (rd_count),
    .err      (err)
  );

  logic [7:0]  mmem [0:65535];
  logic [15:0] exp_wr;
  logic [15:0] exp_rd;
  logic [2:0]  exp_err;
  logic [15:0] pool [0:7];
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, ".wr_count"}, wr_count, exp_wr);
    chk({tag, ".rd_count"}, rd_count, exp_rd);
    chk({tag, ".err"}, err, exp_err);
  endtask

  task automatic idle(input int n);
    bus.ram_we_ = 1'b1;
    bus.ram_oe_ = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle.dq_oe", bus.ram_dq_oe, 0);
    end
  endtask

  // Write pulse of n low samples; data on the last low sample is what lands.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d_last, input int n,
                          input bit chg, input logic [15:0] a_alt);
    for (int i = 0; i < n; i++) begin
      bus.ram_addr  = (chg && i >= 1) ? a_alt : a;
      bus.ram_dq_in = (i == n - 1) ? d_last : 8'($urandom);
      bus.ram_we_   = 1'b0;
      bus.ram_oe_   = 1'b1;
      tick();
    end
    bus.ram_we_  = 1'b1;
    bus.ram_addr = a;
    tick();
    if (!TC || n >= T_WP_MIN) begin
      mmem[a] = d_last;
      exp_wr  = exp_wr + 16'd1;
    end else begin
      exp_err[0] = 1'b1;
    end
    if (TC && chg && n >= 2) exp_err[1] = 1'b1;
    chk("write.dq_oe", bus.ram_dq_oe, 0);
    check_counters("write");
  endtask

  // ram_oe_ low for m samples: data valid from the T_ACC-th edge after the first low sample.
  task automatic do_read(input logic [15:0] a, input int m);
    for (int i = 0; i < m; i++) begin
      bus.ram_addr = a;
      bus.ram_oe_  = 1'b0;
      bus.ram_we_  = 1'b1;
      tick();
      chk("read.dq_oe", bus.ram_dq_oe, (i >= T_ACC) ? 1 : 0);
      if (i >= T_ACC) chk("read.dq_out", bus.ram_dq_out, mmem[a]);
    end
    bus.ram_oe_ = 1'b1;
    tick();
    chk("read_end.dq_oe", bus.ram_dq_oe, 0);
    if (m > T_ACC) exp_rd = exp_rd + 16'd1;
    check_counters("read");
  endtask

  // Read for r samples, then ram_we_ joins while ram_oe_ stays low for n samples.
  task automatic do_collide(input logic [15:0] a, input int r, input int n, input logic [7:0] d_last);
    for (int i = 0; i < r; i++) begin
      bus.ram_addr = a;
      bus.ram_oe_  = 1'b0;
      bus.ram_we_  = 1'b1;
      tick();
      chk("coll_rd.dq_oe", bus.ram_dq_oe, (i >= T_ACC) ? 1 : 0);
    end
    for (int i = 0; i < n; i++) begin
      bus.ram_we_   = 1'b0;
      bus.ram_dq_in = (i == n - 1) ? d_last : 8'($urandom);
      tick();
      chk("coll_wr.dq_oe", bus.ram_dq_oe, 0);
    end
    bus.ram_we_ = 1'b1;
    bus.ram_oe_ = 1'b1;
    tick();
    if (TC) exp_err[2] = 1'b1;
    if (!TC || n >= T_WP_MIN) begin
      mmem[a] = d_last;
      exp_wr  = exp_wr + 16'd1;
    end else begin
      exp_err[0] = 1'b1;
    end
    check_counters("collide");
  endtask

  // Address moves while data is valid: access restarts and new data appears T_ACC edges later.
  task automatic do_read_move(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i <= T_ACC; i++) begin
      bus.ram_addr = a;
      bus.ram_oe_  = 1'b0;
      bus.ram_we_  = 1'b1;
      tick();
    end
    chk("move.dq_out_a", bus.ram_dq_out, mmem[a]);
    bus.ram_addr = b;
    tick();
    chk("move.dq_oe_drop", bus.ram_dq_oe, 0);
    for (int j = 1; j <= T_ACC; j++) begin
      tick();
      chk("move.dq_oe", bus.ram_dq_oe, (j == T_ACC) ? 1 : 0);
    end
    chk("move.dq_out_b", bus.ram_dq_out, mmem[b]);
    bus.ram_oe_ = 1'b1;
    tick();
    if (TC) exp_err[1] = 1'b1;
    exp_rd = exp_rd + 16'd1;
    check_counters("move");
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    exp_wr  = 16'h0;
    exp_rd  = 16'h0;
    exp_err = 3'b000;
    pool[0] = 16'h0000; pool[1] = 16'h0010; pool[2] = 16'h1234; pool[3] = 16'h8001;
    pool[4] = 16'hABCD; pool[5] = 16'h0020; pool[6] = 16'hFFFE; pool[7] = 16'hFFFF;

    rst           = 1'b1;
    bus.ram_addr  = '0;
    bus.ram_we_   = 1'b1;
    bus.ram_oe_   = 1'b1;
    bus.ram_dq_in = 8'h00;
    tick();
    tick();
    chk("reset.dq_oe", bus.ram_dq_oe, 0);
    chk("reset.dq_out", bus.ram_dq_out, 0);
    check_counters("reset");
    rst = 1'b0;
    idle(1);

    do_write(16'h0010, 8'hA5, 4, 1'b0, 16'h0);
    do_read(16'h0010, 4);
    do_write(16'h0010, 8'h3C, 2, 1'b0, 16'h0);
    do_read(16'h0010, 3);
    do_collide(16'h0020, 1, 3, 8'h5E);
    do_write(16'hFFFE, 8'h02, 3, 1'b0, 16'h0);
    do_write(16'hFFFF, 8'h00, 4, 1'b0, 16'h0);
    do_read(16'hFFFE, 4);
    do_read(16'hFFFF, 4);

    for (int i = 0; i < 8; i++) do_write(pool[i], 8'($urandom), 4, 1'b0, 16'h0);
    do_write(pool[1], 8'h77, 4, 1'b1, pool[2]);
    do_write(pool[3], 8'h11, 3, 1'b0, 16'h0);
    do_write(pool[4], 8'hEE, 3, 1'b0, 16'h0);
    do_read_move(pool[3], pool[4]);
    do_read(pool[1], T_ACC);

    for (int t = 0; t < 80; t++) begin
      int kind;
      logic [15:0] a;
      kind = int'($urandom_range(0, 2));
      a    = pool[$urandom_range(0, 7)];
      case (kind)
        0:       do_write(a, 8'($urandom), int'($urandom_range(1, 6)), 1'b0, 16'h0);
        1:       do_read(a, int'($urandom_range(1, 6)));
        default: do_collide(a, int'($urandom_range(1, 4)), int'($urandom_range(1, 5)), 8'($urandom));
      endcase
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end

    for (int i = 0; i <= T_ACC; i++) begin
      bus.ram_addr = pool[6];
      bus.ram_oe_  = 1'b0;
      bus.ram_we_  = 1'b1;
      tick();
    end
    chk("prerst.dq_oe", bus.ram_dq_oe, 1);
    rst = 1'b1;
    tick();
    exp_wr  = 16'h0;
    exp_rd  = 16'h0;
    exp_err = 3'b000;
    chk("midrst.dq_oe", bus.ram_dq_oe, 0);
    chk("midrst.dq_out", bus.ram_dq_out, 0);
    check_counters("midrst");
    rst         = 1'b0;
    bus.ram_oe_ = 1'b1;
    idle(1);
    do_read(pool[6], 4);
    do_read(pool[3], 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
